// File: rtl/station_sequencer.sv
// Station walker for the rover washer handler: debounces the IR trigger, averages
// XADC samples, classifies temperature and drops/picks the washer at matching pillars.
module station_sequencer #(
  parameter int unsigned               NUM_STATIONS = 4,
  parameter int unsigned               IDX_W        = 2,
  parameter int unsigned               TEMP_W       = 12,
  parameter int unsigned               TH_COLD      = 1200,
  parameter int unsigned               TH_HOT       = 1900,
  parameter logic [2*NUM_STATIONS-1:0] STATION_MAP  = 8'h24,
  parameter int unsigned               AVG_LOG2     = 2,
  parameter int unsigned               DEB_CYC      = 16,
  parameter int unsigned               SERVO_HOLD   = 500,
  parameter int unsigned               WRAP         = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              trigger,
  input  logic [TEMP_W-1:0] digital_temp,
  input  logic              ready,
  output logic              correct_station,
  output logic              control_em,
  output logic              control_servo,
  output logic [IDX_W-1:0]  station_idx,
  output logic [1:0]        temp_class,
  output logic [7:0]        wrong_count,
  output logic              done
);

  localparam int unsigned ACC_W  = TEMP_W + AVG_LOG2;
  localparam int unsigned SMP_W  = AVG_LOG2 + 1;
  localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
  localparam int unsigned HOLD_W = $clog2(SERVO_HOLD + 1);

  localparam logic [SMP_W-1:0]  SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(SERVO_HOLD);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_STATIONS - 1);
  localparam logic [TEMP_W-1:0] COLD_LIM = TEMP_W'(TH_COLD);
  localparam logic [TEMP_W-1:0] HOT_LIM  = TEMP_W'(TH_HOT);

  localparam logic [1:0] CLS_AMB  = 2'd0;
  localparam logic [1:0] CLS_HOT  = 2'd1;
  localparam logic [1:0] CLS_COLD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_DECIDE, S_DROP, S_LEAVE, S_FIND, S_PICKUP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                trig_db;
  logic [DEB_W-1:0]    deb_cnt;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SMP_W-1:0]    smp_q, smp_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                cs_d, em_d, servo_d, done_d;
  logic [IDX_W-1:0]    idx_d;
  logic [1:0]          cls_d, cls_now, map_cls;
  logic [7:0]          wrong_d;
  logic [TEMP_W-1:0]   avg;
  logic                match;

  // Input changes only after DEB_CYC consecutive cycles of disagreement.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trig_db <= 1'b0;
      deb_cnt <= '0;
    end else if (trigger == trig_db) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      trig_db <= trigger;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign avg     = acc_q[ACC_W-1:AVG_LOG2];
  assign cls_now = (avg <= COLD_LIM) ? CLS_COLD : (avg >= HOT_LIM) ? CLS_HOT : CLS_AMB;
  assign map_cls = 2'(STATION_MAP >> {station_idx, 1'b0});
  assign match   = (cls_now == map_cls);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (trig_db) state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (!trig_db)                        state_d = S_IDLE;
        else if (ready && smp_q == SMP_LAST) state_d = S_DECIDE;
      end
      S_DECIDE: state_d = match ? S_DROP : S_LEAVE;
      S_DROP:   state_d = (station_idx == LAST_IDX && WRAP == 0) ? S_DONE : S_LEAVE;
      S_LEAVE:  if (!trig_db) state_d = S_FIND;
      S_FIND:   if (trig_db) state_d = S_PICKUP;
      S_PICKUP: if (hold_q == HOLD_MAX && !trig_db) state_d = S_IDLE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    acc_d   = acc_q;
    smp_d   = smp_q;
    hold_d  = hold_q;
    cs_d    = correct_station;
    em_d    = control_em;
    servo_d = control_servo;
    idx_d   = station_idx;
    cls_d   = temp_class;
    wrong_d = wrong_count;
    done_d  = done;
    case (state_q)
      S_IDLE: begin
        servo_d = 1'b0;
        cs_d    = 1'b0;
        acc_d   = '0;
        smp_d   = '0;
      end
      S_SAMPLE: begin
        if (trig_db && ready) begin
          acc_d = acc_q + ACC_W'(digital_temp);
          smp_d = smp_q + 1'b1;
        end
      end
      S_DECIDE: begin
        cls_d = cls_now;
        if (!match && wrong_count != 8'hFF) wrong_d = wrong_count + 8'd1;
      end
      S_DROP: begin
        em_d = 1'b0;
        cs_d = 1'b1;
        if (station_idx == LAST_IDX) begin
          if (WRAP != 0) idx_d = '0;
          else           done_d = 1'b1;
        end else begin
          idx_d = station_idx + 1'b1;
        end
      end
      S_FIND: if (trig_db) hold_d = '0;
      S_PICKUP: begin
        em_d    = 1'b1;
        servo_d = correct_station;
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
      end
      S_DONE: begin
        servo_d = 1'b0;
        em_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q           <= '0;
      smp_q           <= '0;
      hold_q          <= '0;
      correct_station <= 1'b0;
      control_em      <= 1'b0;
      control_servo   <= 1'b0;
      station_idx     <= '0;
      temp_class      <= '0;
      wrong_count     <= '0;
      done            <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      smp_q           <= smp_d;
      hold_q          <= hold_d;
      correct_station <= cs_d;
      control_em      <= em_d;
      control_servo   <= servo_d;
      station_idx     <= idx_d;
      temp_class      <= cls_d;
      wrong_count     <= wrong_d;
      done            <= done_d;
    end
  end

endmodule

// File: tb/tb_station_sequencer.sv
// Directed bench for station_sequencer: a wrapping instance, a non-wrapping twin on the
// same stimulus, and a fast-timing instance used to reach wrong_count saturation.
module tb_station_sequencer;

  logic        CLK, RST;
  logic        trigger, ready;
  logic [11:0] digital_temp;
  logic        correct_station, control_em, control_servo, done;
  logic [1:0]  station_idx, temp_class;
  logic [7:0]  wrong_count;

  logic        cs_nw, em_nw, servo_nw, done_nw;
  logic [1:0]  idx_nw, cls_nw;
  logic [7:0]  wrong_nw;

  logic        trig_f, ready_f;
  logic [11:0] temp_f;
  logic        cs_f, em_f, servo_f, done_f;
  logic [0:0]  idx_f;
  logic [1:0]  cls_f;
  logic [7:0]  wrong_f;

  int n_checks = 0;
  int n_err    = 0;

  station_sequencer dut (
    .CLK(CLK), .RST(RST), .trigger(trigger), .digital_temp(digital_temp), .ready(ready),
    .correct_station(correct_station), .control_em(control_em), .control_servo(control_servo),
    .station_idx(station_idx), .temp_class(temp_class), .wrong_count(wrong_count), .done(done)
  );

  station_sequencer #(.WRAP(0)) dut_nw (
    .CLK(CLK), .RST(RST), .trigger(trigger), .digital_temp(digital_temp), .ready(ready),
    .correct_station(cs_nw), .control_em(em_nw), .control_servo(servo_nw),
    .station_idx(idx_nw), .temp_class(cls_nw), .wrong_count(wrong_nw), .done(done_nw)
  );

  station_sequencer #(
    .NUM_STATIONS(2), .IDX_W(1), .STATION_MAP(4'h1), .AVG_LOG2(0),
    .DEB_CYC(2), .SERVO_HOLD(1)
  ) dut_fast (
    .CLK(CLK), .RST(RST), .trigger(trig_f), .digital_temp(temp_f), .ready(ready_f),
    .correct_station(cs_f), .control_em(em_f), .control_servo(servo_f),
    .station_idx(idx_f), .temp_class(cls_f), .wrong_count(wrong_f), .done(done_f)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Trigger rises with ready already high (must be ignored before SAMPLE), then four
  // back-to-back samples; the decision shows on the outputs 23 cycles after the rise.
  task automatic arrive(input logic [11:0] t0, input logic [11:0] t1, input logic [11:0] t2,
                        input logic [11:0] t3, input logic exp_cs, input logic [1:0] exp_cls,
                        input logic [1:0] exp_idx, input logic [7:0] exp_wrong,
                        input logic exp_em);
    logic [11:0] s [4];
    s = '{t0, t1, t2, t3};
    trigger = 1'b1; ready = 1'b1; digital_temp = 12'hFFF;
    tick(17);
    for (int i = 0; i < 4; i++) begin
      digital_temp = s[i];
      tick(1);
    end
    ready = 1'b0;
    tick(1);
    chk("cs_before_drop", correct_station, 1'b0);
    tick(1);
    chk("correct_station", correct_station, exp_cs);
    chk("em_after_decide", control_em, exp_em);
    chk("station_idx", station_idx, exp_idx);
    chk("temp_class", temp_class, exp_cls);
    chk("wrong_count", wrong_count, exp_wrong);
  endtask

  // Leave, return, and hold PICKUP with the trigger dropped ~100 cycles into the hold.
  task automatic depart(input logic exp_servo);
    trigger = 1'b0;
    tick(20);
    trigger = 1'b1;
    tick(18);
    chk("pickup_em", control_em, 1'b1);
    chk("pickup_servo", control_servo, exp_servo);
    tick(99);
    trigger = 1'b0;
    tick(83);
    chk("pickup_early_drop_servo", control_servo, exp_servo);
    tick(318);
    chk("pickup_last_cycle_servo", control_servo, exp_servo);
    tick(1);
    chk("idle_servo_up", control_servo, 1'b0);
    chk("idle_em_held", control_em, 1'b1);
    chk("idle_cs_clear", correct_station, 1'b0);
  endtask

  initial begin
    RST = 1'b1; trigger = 1'b0; ready = 1'b0; digital_temp = '0;
    trig_f = 1'b0; ready_f = 1'b1; temp_f = '0;
    tick(3);
    RST = 1'b0;
    tick(1);
    chk("rst_cs", correct_station, 1'b0);
    chk("rst_em", control_em, 1'b0);
    chk("rst_servo", control_servo, 1'b0);
    chk("rst_idx", station_idx, 2'd0);
    chk("rst_cls", temp_class, 2'd0);
    chk("rst_wrong", wrong_count, 8'd0);
    chk("rst_done", done, 1'b0);

    // Station 0 ambient
    arrive(12'd1500, 12'd1500, 12'd1500, 12'd1500, 1'b1, 2'd0, 2'd1, 8'd0, 1'b0);
    depart(1'b1);

    // Glitch shorter than the debounce window
    trigger = 1'b1;
    tick(10);
    chk("glitch_trig_db", dut.trig_db, 1'b0);
    trigger = 1'b0;
    tick(30);
    chk("glitch_cs", correct_station, 1'b0);
    chk("glitch_em", control_em, 1'b1);
    chk("glitch_servo", control_servo, 1'b0);
    chk("glitch_idx", station_idx, 2'd1);

    // Station 1 hot: ambient reading is wrong, then avg 1925 is right
    arrive(12'd1800, 12'd1800, 12'd1800, 12'd1800, 1'b0, 2'd0, 2'd1, 8'd1, 1'b1);
    depart(1'b0);
    arrive(12'd1800, 12'd2000, 12'd2000, 12'd1900, 1'b1, 2'd1, 2'd2, 8'd1, 1'b0);
    depart(1'b1);

    // Station 2 cold at the boundary: 4803>>2 = 1200
    arrive(12'd1200, 12'd1200, 12'd1200, 12'd1203, 1'b1, 2'd2, 2'd3, 8'd1, 1'b0);
    depart(1'b1);

    // Station 3 ambient just under hot: 7599>>2 = 1899
    arrive(12'd1899, 12'd1899, 12'd1899, 12'd1902, 1'b1, 2'd0, 2'd0, 8'd1, 1'b0);
    chk("nw_done", done_nw, 1'b1);
    chk("nw_idx_held", idx_nw, 2'd3);
    chk("nw_cs", cs_nw, 1'b1);
    chk("wrap_done_low", done, 1'b0);
    depart(1'b1);
    chk("nw_done_em", em_nw, 1'b0);
    chk("nw_done_servo", servo_nw, 1'b0);
    chk("nw_done_cs", cs_nw, 1'b1);

    // Wrapped back to station 0; the non-wrapping twin ignores the visit
    arrive(12'd1500, 12'd1500, 12'd1500, 12'd1500, 1'b1, 2'd0, 2'd1, 8'd1, 1'b0);
    chk("nw_still_done", done_nw, 1'b1);
    chk("nw_still_idx", idx_nw, 2'd3);
    chk("nw_wrong_held", wrong_nw, 8'd1);
    depart(1'b1);

    // Station 1 at exactly TH_HOT, then async reset in the middle of PICKUP
    arrive(12'd1900, 12'd1900, 12'd1900, 12'd1900, 1'b1, 2'd1, 2'd2, 8'd1, 1'b0);
    trigger = 1'b0;
    tick(20);
    trigger = 1'b1;
    tick(18);
    chk("pre_rst_em", control_em, 1'b1);
    chk("pre_rst_servo", control_servo, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_em", control_em, 1'b0);
    chk("async_rst_servo", control_servo, 1'b0);
    chk("async_rst_cs", correct_station, 1'b0);
    chk("async_rst_idx", station_idx, 2'd0);
    chk("async_rst_wrong", wrong_count, 8'd0);
    chk("async_rst_nw_done", done_nw, 1'b0);
    trigger = 1'b0;
    tick(2);
    RST = 1'b0;
    tick(1);

    // Reset with 2 of 4 samples taken; the next visit must gather 4 fresh samples
    trigger = 1'b1; ready = 1'b0;
    tick(17);
    digital_temp = 12'd1500; ready = 1'b1;
    tick(2);
    ready = 1'b0;
    #2 RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("smp_rst_cs", correct_station, 1'b0);
    chk("smp_rst_idx", station_idx, 2'd0);
    chk("smp_rst_cls", temp_class, 2'd0);
    tick(17);
    ready = 1'b1;
    tick(3);
    ready = 1'b0;
    tick(5);
    chk("fresh_three_samples_no_drop", correct_station, 1'b0);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(2);
    chk("fresh_fourth_sample_drop", correct_station, 1'b1);
    chk("fresh_idx", station_idx, 2'd1);
    chk("fresh_cls", temp_class, 2'd0);
    trigger = 1'b0;

    // 300 wrong decisions on the fast instance
    for (int i = 1; i <= 300; i++) begin
      trig_f = 1'b1; tick(8);
      trig_f = 1'b0; tick(8);
      trig_f = 1'b1; tick(8);
      trig_f = 1'b0; tick(8);
      if (i == 1 || i == 255 || i == 300)
        chk("wrong_count_sat", wrong_f, (i > 255) ? 255 : i);
    end
    chk("fast_idx", idx_f, 1'b0);
    chk("fast_cls", cls_f, 2'd2);
    chk("fast_cs", cs_f, 1'b0);
    chk("fast_em", em_f, 1'b1);
    chk("fast_servo", servo_f, 1'b0);
    chk("fast_done", done_f, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/station_sequencer.md
Name: station_sequencer

Overview:
Parametrised successor to the rover's material-handling controller.
- Walks a configurable list of NUM_STATIONS pillars, each tagged ambient, hot or cold.
- Debounces the IR station trigger and averages several XADC samples before classifying temperature.
- Drops the washer at the correct station and picks up the next one.
- Drives the 7-segment trigger, EM and servo, plus status counters for the top-level station system.

Parameters:
NUM_STATIONS, 4, number of stations in the sequence (>=2)
IDX_W, 2, width of station_idx (>= clog2(NUM_STATIONS))
TEMP_W, 12, XADC sample width
TH_COLD, 1200, average <= TH_COLD classifies as cold
TH_HOT, 1900, average >= TH_HOT classifies as hot; otherwise ambient
STATION_MAP, 8'h24, 2 bits per station, station i = bits [2i+1:2i]; 0=ambient, 1=hot, 2=cold (default: amb, hot, cold, amb)
AVG_LOG2, 2, 2^AVG_LOG2 samples averaged per decision
DEB_CYC, 16, cycles trigger must be stable before the debounced value changes
SERVO_HOLD, 500, minimum PICKUP cycles
WRAP, 1, 1: wrap to station 0 after last; 0: enter DONE

Ports:
CLK  in  1  system clock (ACLK)
RST  in  1  asynchronous, active-high reset
trigger  in  1  raw IR station detect, 1 = pillar present
digital_temp  in  TEMP_W  XADC temperature code
ready  in  1  XADC sample-valid
correct_station  out  1  level; high from DROP until next IDLE (drives 7-seg system)
control_em  out  1  electromagnet, 1 = ON
control_servo  out  1  servo, 0 = UP, 1 = DOWN
station_idx  out  IDX_W  index of the station currently expected
temp_class  out  2  class of last decision (0/1/2)
wrong_count  out  8  saturating count of wrong-station decisions
done  out  1  sequence complete (WRAP=0 only)

Behaviour:
- Reset (async, any state):
  - state=IDLE, trig_db=0, debounce counter=0, accumulator=0.
  - correct_station=0, control_em=0, control_servo=0 (UP), station_idx=0, temp_class=0, wrong_count=0, done=0.
- Debounce:
  - Counter clears whenever trigger==trig_db.
  - Otherwise it increments; on reaching DEB_CYC-1, trig_db<=trigger and counter clears.
  - Effect: a clean edge propagates to trig_db DEB_CYC cycles after the raw edge.
  - Glitches shorter than DEB_CYC are fully rejected.
  - The FSM uses trig_db only.
- States:
  - IDLE: control_servo<=UP, correct_station<=0, accumulator/sample count cleared. If trig_db==1 -> SAMPLE.
  - SAMPLE:
    - Each cycle with ready==1 adds digital_temp into accumulator (TEMP_W+AVG_LOG2 bits, no overflow) and increments sample count.
    - After 2^AVG_LOG2 samples -> DECIDE.
    - trig_db falling in SAMPLE -> IDLE, no counters change.
    - ready outside SAMPLE is ignored.
  - DECIDE (1 cycle):
    - avg = accumulator >> AVG_LOG2 (truncating).
    - Class: cold if avg<=TH_COLD, hot if avg>=TH_HOT, else ambient.
    - temp_class<=class.
    - Class == STATION_MAP[station_idx] -> DROP.
    - Otherwise wrong_count<=wrong_count+1 (holds at 255) -> LEAVE.
  - DROP (1 cycle):
    - control_em<=0, correct_station<=1.
    - If station_idx==NUM_STATIONS-1: WRAP=1 -> station_idx<=0, go LEAVE; WRAP=0 -> done<=1, go DONE.
    - Otherwise station_idx+1, go LEAVE.
  - LEAVE: wait trig_db==0 -> FIND.
  - FIND: wait trig_db==1 -> PICKUP, hold counter<=0.
  - PICKUP:
    - control_em<=1; control_servo<=DOWN if correct_station==1 else UP.
    - Hold counter increments, saturating at SERVO_HOLD.
    - -> IDLE only when counter==SERVO_HOLD and trig_db==0.
    - An early trigger drop keeps the FSM in PICKUP until the hold expires.
  - DONE: control_servo=UP, control_em=0, correct_station holds 1; terminal until RST.
  - Undefined state encodings -> IDLE.
- Boundaries and latency:
  - control_em is untouched in IDLE, SAMPLE, DECIDE, LEAVE and FIND, so a held washer stays held.
  - Latency from clean trigger rise to SAMPLE entry is DEB_CYC+1 cycles.
  - RST mid-PICKUP drops EM and raises servo immediately (asynchronous).
- All outputs are registered.

Test Plan:
- Reset, then trigger=1 held, ready pulsed 4x with digital_temp=1500 at station 0 (ambient) -> after 16+1 cycles enters SAMPLE; after 4 ready samples correct_station=1, control_em=0, station_idx=1, temp_class=0.
- Station 1 (hot) with samples 1800,2000,2000,1900 (avg 1925) -> hot, DROP; samples 1800x4 instead -> ambient, wrong_count=1, correct_station stays 0, station_idx unchanged.
- 10-cycle glitch on trigger in IDLE -> trig_db stays 0, FSM stays IDLE, no output change.
- PICKUP after a correct drop, trigger released 100 cycles in -> control_servo=DOWN, control_em=1 until cycle 500, then IDLE with servo UP and EM still 1.
- Walk all 4 stations correctly with WRAP=0 -> done=1 after station 3, FSM in DONE, further triggers ignored. With WRAP=1 -> station_idx returns to 0.
- Assert RST during SAMPLE with 2 of 4 samples taken, then release -> all outputs at reset values; next visit requires 4 fresh samples. Also drive 300 wrong decisions -> wrong_count saturates at 255.
